control_unit: RTL and testbench

- Multicycle MIPS controller: Moore main FSM plus ALU decoder.
- Consumes opcode/funct from the instruction register of the multicycle datapath; drives every datapath control input (mux selects, write enables, branch, alu_control).
- Sits directly upstream of the datapath on the control path; the datapath's PC/IR/A/B/ALUOut registers hold state between FSM steps.

---
 rtl/control_pkg.sv | 50 +++++
 rtl/control_unit_alu_decoder.sv | 29 ++
 rtl/control_unit.sv | 149 ++++++++++++++
 tb/tb_control_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared types and encodings for the multicycle MIPS controller.
package control_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXEC   = 4'd7,
    ALUWB  = 4'd8,
    BEQ    = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11,
    JUMP   = 4'd12,
    HALT   = 4'd13
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  function automatic logic is_legal_opcode(input logic [5:0] op);
    return op inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J};
  endfunction

endpackage

// File: rtl/control_unit_alu_decoder.sv
// ALU decoder: maps the FSM's alu_op and the instruction funct field to alu_control.
module alu_decoder
  import control_pkg::*;
(
  input  alu_op_t    i_alu_op,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_control
);

  always_comb begin
    // NOTE: assign a default before the case so every path drives the output and no latch is inferred.
    o_alu_control = ALU_ADD;
    case (i_alu_op)
      ALUOP_SUB: o_alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          F_ADD:   o_alu_control = ALU_ADD;
          F_SUB:   o_alu_control = ALU_SUB;
          F_AND:   o_alu_control = ALU_AND;
          F_OR:    o_alu_control = ALU_OR;
          F_SLT:   o_alu_control = ALU_SLT;
          default: o_alu_control = ALU_ADD;
        endcase
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multicycle MIPS controller: Moore main FSM with combinational state decode
// driving every datapath control input, plus the ALU decoder.
module control_unit
  import control_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       mem_to_reg,
  output logic       reg_dest,
  output logic       i_or_d,
  output logic       alu_src_a,
  output logic       ir_write,
  output logic       mem_write,
  output logic       pc_write,
  output logic       branch,
  output logic       reg_write,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alu_control,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op
);

  state_t  r_state;
  alu_op_t w_alu_op;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:   r_state <= FETCH;
        FETCH:  r_state <= DECODE;
        DECODE: begin
          case (opcode)
            OP_LW, OP_SW: r_state <= MEMADR;
            OP_RTYPE:     r_state <= EXEC;
            OP_BEQ:       r_state <= BEQ;
            OP_ADDI:      r_state <= ADDIEX;
            OP_J:         r_state <= JUMP;
            default:      r_state <= ILLEGAL_HALT ? HALT : FETCH;
          endcase
        end
        // IR is not rewritten after FETCH, so opcode still selects lw vs sw here.
        MEMADR: r_state <= (opcode == OP_LW) ? MEMRD : MEMWR;
        MEMRD:  r_state <= MEMWB;
        MEMWB:  r_state <= FETCH;
        MEMWR:  r_state <= FETCH;
        EXEC:   r_state <= ALUWB;
        ALUWB:  r_state <= FETCH;
        BEQ:    r_state <= FETCH;
        ADDIEX: r_state <= ADDIWB;
        ADDIWB: r_state <= FETCH;
        JUMP:   r_state <= FETCH;
        HALT:   r_state <= HALT;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outputs follow the state register directly, so an async reset kills any write at once.
  always_comb begin
    mem_to_reg = 1'b0;
    reg_dest   = 1'b0;
    i_or_d     = 1'b0;
    alu_src_a  = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    reg_write  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    w_alu_op   = ALUOP_ADD;
    case (r_state)
      FETCH: begin
        ir_write  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = 1'b1;
      end
      DECODE: begin
        alu_src_b  = 2'b11;
        illegal_op = !is_legal_opcode(opcode);
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD: i_or_d = 1'b1;
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      MEMWR: begin
        i_or_d     = 1'b1;
        mem_write  = 1'b1;
        instr_done = 1'b1;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        w_alu_op  = ALUOP_FUNCT;
      end
      ALUWB: begin
        reg_dest   = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      BEQ: begin
        alu_src_a  = 1'b1;
        w_alu_op   = ALUOP_SUB;
        pc_src     = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      JUMP: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .i_alu_op      (w_alu_op),
    .i_funct       (funct),
    .o_alu_control (alu_control)
  );

  assign state = r_state;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: latency/decode vector table, randomized
// instruction stream against a per-instruction trace model, reset and HALT sequences.
module tb_control_unit;
  import control_pkg::*;

  typedef struct packed {
    logic [3:0] state;
    logic       mem_to_reg;
    logic       reg_dest;
    logic       i_or_d;
    logic       alu_src_a;
    logic       ir_write;
    logic       mem_write;
    logic       pc_write;
    logic       branch;
    logic       reg_write;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_control;
    logic       instr_done;
    logic       illegal_op;
  } ctl_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int         lat;
    logic       ill;
    logic [2:0] alu3;
    int         done;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct, opcode2, funct2;

  logic       mem_to_reg1, reg_dest1, i_or_d1, alu_src_a1, ir_write1, mem_write1;
  logic       pc_write1, branch1, reg_write1, instr_done1, illegal_op1;
  logic [1:0] alu_src_b1, pc_src1;
  logic [2:0] alu_control1;
  logic [3:0] state1;
  logic       mem_to_reg2, reg_dest2, i_or_d2, alu_src_a2, ir_write2, mem_write2;
  logic       pc_write2, branch2, reg_write2, instr_done2, illegal_op2;
  logic [1:0] alu_src_b2, pc_src2;
  logic [2:0] alu_control2;
  logic [3:0] state2;
  ctl_t       act1, act2;

  int total = 0;
  int bad   = 0;
  logic [2:0] fmap [logic [5:0]];
  ctl_t exp_q[$];

  always #5 clk = ~clk;

  control_unit #(.ILLEGAL_HALT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .mem_to_reg(mem_to_reg1), .reg_dest(reg_dest1), .i_or_d(i_or_d1),
    .alu_src_a(alu_src_a1), .ir_write(ir_write1), .mem_write(mem_write1),
    .pc_write(pc_write1), .branch(branch1), .reg_write(reg_write1),
    .alu_src_b(alu_src_b1), .pc_src(pc_src1), .alu_control(alu_control1),
    .state(state1), .instr_done(instr_done1), .illegal_op(illegal_op1)
  );

  control_unit #(.ILLEGAL_HALT(1'b1)) dut_halt (
    .clk(clk), .rst_n(rst_n), .opcode(opcode2), .funct(funct2),
    .mem_to_reg(mem_to_reg2), .reg_dest(reg_dest2), .i_or_d(i_or_d2),
    .alu_src_a(alu_src_a2), .ir_write(ir_write2), .mem_write(mem_write2),
    .pc_write(pc_write2), .branch(branch2), .reg_write(reg_write2),
    .alu_src_b(alu_src_b2), .pc_src(pc_src2), .alu_control(alu_control2),
    .state(state2), .instr_done(instr_done2), .illegal_op(illegal_op2)
  );

  assign act1 = {state1, mem_to_reg1, reg_dest1, i_or_d1, alu_src_a1, ir_write1, mem_write1,
                 pc_write1, branch1, reg_write1, alu_src_b1, pc_src1, alu_control1,
                 instr_done1, illegal_op1};
  assign act2 = {state2, mem_to_reg2, reg_dest2, i_or_d2, alu_src_a2, ir_write2, mem_write2,
                 pc_write2, branch2, reg_write2, alu_src_b2, pc_src2, alu_control2,
                 instr_done2, illegal_op2};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic ctl_t base(input logic [3:0] st);
    ctl_t c;
    c = '0;
    c.alu_control = 3'b010;
    c.state       = st;
    return c;
  endfunction

  // Expected per-cycle control trace of one instruction, starting at its FETCH cycle.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input bit halt_mode);
    ctl_t c;
    logic legal;
    legal = op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    exp_q = {};
    c = base(FETCH);  c.ir_write = 1'b1; c.pc_write = 1'b1; c.alu_src_b = 2'b01; exp_q.push_back(c);
    c = base(DECODE); c.alu_src_b = 2'b11; c.illegal_op = !legal; exp_q.push_back(c);
    case (op)
      6'b100011: begin
        c = base(MEMADR); c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; exp_q.push_back(c);
        c = base(MEMRD);  c.i_or_d = 1'b1; exp_q.push_back(c);
        c = base(MEMWB);  c.mem_to_reg = 1'b1; c.reg_write = 1'b1; c.instr_done = 1'b1; exp_q.push_back(c);
      end
      6'b101011: begin
        c = base(MEMADR); c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; exp_q.push_back(c);
        c = base(MEMWR);  c.i_or_d = 1'b1; c.mem_write = 1'b1; c.instr_done = 1'b1; exp_q.push_back(c);
      end
      6'b000000: begin
        c = base(EXEC); c.alu_src_a = 1'b1;
        c.alu_control = fmap.exists(fn) ? fmap[fn] : 3'b010;
        exp_q.push_back(c);
        c = base(ALUWB); c.reg_dest = 1'b1; c.reg_write = 1'b1; c.instr_done = 1'b1; exp_q.push_back(c);
      end
      6'b000100: begin
        c = base(BEQ); c.alu_src_a = 1'b1; c.alu_control = 3'b110; c.pc_src = 2'b01;
        c.branch = 1'b1; c.instr_done = 1'b1; exp_q.push_back(c);
      end
      6'b001000: begin
        c = base(ADDIEX); c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; exp_q.push_back(c);
        c = base(ADDIWB); c.reg_write = 1'b1; c.instr_done = 1'b1; exp_q.push_back(c);
      end
      6'b000010: begin
        c = base(JUMP); c.pc_src = 2'b10; c.pc_write = 1'b1; c.instr_done = 1'b1; exp_q.push_back(c);
      end
      default: if (halt_mode) exp_q.push_back(base(HALT));
    endcase
  endtask

  vec_t vecs[$];
  logic [5:0] known_fn [5];

  initial begin
    ctl_t c;
    fmap[6'b100000] = 3'b010;
    fmap[6'b100010] = 3'b110;
    fmap[6'b100100] = 3'b000;
    fmap[6'b100101] = 3'b001;
    fmap[6'b101010] = 3'b111;
    known_fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    //            op         fn         lat ill alu3    done
    vecs.push_back('{6'b100011, 6'b000000, 5, 1'b0, 3'b010, 1});
    vecs.push_back('{6'b101011, 6'b000000, 4, 1'b0, 3'b010, 1});
    vecs.push_back('{6'b000000, 6'b100000, 4, 1'b0, 3'b010, 1});
    vecs.push_back('{6'b000000, 6'b100010, 4, 1'b0, 3'b110, 1});
    vecs.push_back('{6'b000000, 6'b101010, 4, 1'b0, 3'b111, 1});
    vecs.push_back('{6'b000000, 6'b100100, 4, 1'b0, 3'b000, 1});
    vecs.push_back('{6'b000000, 6'b100101, 4, 1'b0, 3'b001, 1});
    vecs.push_back('{6'b000000, 6'b111111, 4, 1'b0, 3'b010, 1});
    vecs.push_back('{6'b000100, 6'b000000, 3, 1'b0, 3'b110, 1});
    vecs.push_back('{6'b001000, 6'b000000, 4, 1'b0, 3'b010, 1});
    vecs.push_back('{6'b000010, 6'b000000, 3, 1'b0, 3'b010, 1});
    vecs.push_back('{6'b111111, 6'b000000, 2, 1'b1, 3'b010, 0});
    vecs.push_back('{6'b000001, 6'b000000, 2, 1'b1, 3'b010, 0});

    rst_n   = 1'b0;
    opcode  = 6'b100011;
    funct   = 6'b000000;
    opcode2 = 6'b100011;
    funct2  = 6'b000000;
    #1;
    check("reset_idle", 32'(act1), 32'(base(IDLE)));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("release_idle", 32'(act1), 32'(base(IDLE)));
    step();
    build(6'b100011, 6'b0, 1'b0);
    check("first_fetch", 32'(act1), 32'(exp_q[0]));

    // Table: latency back to FETCH, illegal flag in DECODE, alu_control in cycle 3, done count.
    foreach (vecs[v]) begin
      int lat, done_cnt;
      logic ill;
      logic [2:0] alu3;
      opcode = vecs[v].op;
      funct  = vecs[v].fn;
      lat = 0; done_cnt = 0; ill = 1'b0; alu3 = 3'b0;
      while (lat < 10) begin
        step();
        lat++;
        if (lat == 1) ill = illegal_op1;
        if (lat == 2) alu3 = alu_control1;
        if (instr_done1) done_cnt++;
        if (state1 == FETCH) break;
      end
      check($sformatf("vec%0d_latency", v), 32'(lat), 32'(vecs[v].lat));
      check($sformatf("vec%0d_illegal", v), 32'(ill), 32'(vecs[v].ill));
      check($sformatf("vec%0d_alu", v), 32'(alu3), 32'(vecs[v].alu3));
      check($sformatf("vec%0d_done", v), 32'(done_cnt), 32'(vecs[v].done));
    end

    // Randomized instruction stream, every cycle compared against the trace model.
    for (int n = 0; n < 150; n++) begin
      logic [5:0] op, fn;
      case ($urandom_range(0, 6))
        0: op = 6'b100011;
        1: op = 6'b101011;
        2: op = 6'b000000;
        3: op = 6'b000100;
        4: op = 6'b001000;
        5: op = 6'b000010;
        default: begin
          op = 6'($urandom_range(0, 63));
          while (op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010})
            op = 6'($urandom_range(0, 63));
        end
      endcase
      fn = ($urandom_range(0, 1) == 0) ? known_fn[$urandom_range(0, 4)] : 6'($urandom_range(0, 63));
      opcode = op;
      funct  = fn;
      build(op, fn, 1'b0);
      check($sformatf("rand%0d_c0", n), 32'(act1), 32'(exp_q[0]));
      for (int i = 1; i < exp_q.size(); i++) begin
        step();
        check($sformatf("rand%0d_c%0d op=%b fn=%b", n, i, op, fn), 32'(act1), 32'(exp_q[i]));
      end
      step();
    end

    // Asynchronous reset in the middle of a lw read.
    opcode = 6'b100011;
    build(6'b100011, 6'b0, 1'b0);
    check("pre_lw_fetch", 32'(act1), 32'(exp_q[0]));
    repeat (3) step();
    check("in_memrd", 32'(act1), 32'(exp_q[3]));
    #2 rst_n = 1'b0;
    #1;
    check("abort_memrd_idle", 32'(act1), 32'(base(IDLE)));
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_release_idle", 32'(act1), 32'(base(IDLE)));
    step();
    check("abort_refetch", 32'(act1), 32'(exp_q[0]));

    // ILLEGAL_HALT=1 instance: illegal opcode parks in HALT until reset.
    opcode2 = 6'b111111;
    build(6'b111111, 6'b0, 1'b1);
    check("halt_fetch", 32'(act2), 32'(exp_q[0]));
    step();
    check("halt_decode_illegal", 32'(act2), 32'(exp_q[1]));
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("halt_hold%0d", i), 32'(act2), 32'(exp_q[2]));
    end
    #2 rst_n = 1'b0;
    #1;
    check("halt_reset_idle", 32'(act2), 32'(base(IDLE)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
